// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential divider: FSM state encoding
// and a constant-evaluable ceiling log2 used to size counters and shifts.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for the divider: valid/ready on the
// operand side and on the result side.
interface seq_divider_if #(parameter int WIDTH = 4);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_pow2_detect.sv
// Combinational power-of-two check on the divisor; shamt is the index of
// the single set bit when is_pow2_o is high (zero divisor is not a power).
module pow2_detect
    import div_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int SW   = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] divisor_i,
    output logic             is_pow2_o,
    output logic [SW-1:0]    shamt_o
);

    always_comb begin
        is_pow2_o = (divisor_i != '0) &&
                    ((divisor_i & (divisor_i - WIDTH'(1))) == '0);
    end

    always_comb begin
        shamt_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (divisor_i[i]) begin
                shamt_o = SW'(i);
            end
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned divider: single-cycle shift for power-of-two divisors, restoring
// shift-subtract over WIDTH cycles otherwise, valid/ready on both sides.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);

    localparam int CW = clog2(WIDTH + 1);
    localparam int SW = clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] divHold_q, divHold_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   trial;
    logic             isPow2;
    logic [SW-1:0]    shamt;

    pow2_detect #(.WIDTH(WIDTH)) u_pow2 (
        .divisor_i (bus.divisor),
        .is_pow2_o (isPow2),
        .shamt_o   (shamt)
    );

    // The partial remainder is WIDTH+1 bits only while trialling a subtract;
    // after restore its top bit is always zero, so only WIDTH bits are kept.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        shift_d   = shift_q;
        divHold_d = divHold_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        trial     = {acc_q, shift_q[WIDTH-1]};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else if (isPow2) begin
                        quot_d  = bus.dividend >> shamt;
                        rem_d   = bus.dividend & (bus.divisor - WIDTH'(1));
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        acc_d     = '0;
                        shift_d   = bus.dividend;
                        divHold_d = bus.divisor;
                        cnt_d     = CW'(WIDTH);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (trial >= {1'b0, divHold_q}) begin
                    acc_d   = trial[WIDTH-1:0] - divHold_q;
                    shift_d = {shift_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d   = trial[WIDTH-1:0];
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == CW'(1)) begin
                    quot_d  = shift_d;
                    rem_d   = acc_d;
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            shift_q   <= '0;
            divHold_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            shift_q   <= shift_d;
            divHold_q <= divHold_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule
